// File: rtl/ex_alu_unit_if.sv
// Execute-stage ALU bus: ALU select, operands, pipeline qualifiers, and result/stall/done returns.
interface ex_alu_unit_if;
  logic [3:0]  ALU_Control_EX;
  logic [31:0] ALU_A_EX;
  logic [31:0] ALU_B_EX;
  logic        Valid_EX;
  logic        Flush_EX;
  logic [31:0] ALU_Result_EX;
  logic        Zero_EX;
  logic        Stall_EX;
  logic        Mul_Done_EX;

  modport master (
    output ALU_Control_EX, ALU_A_EX, ALU_B_EX, Valid_EX, Flush_EX,
    input  ALU_Result_EX, Zero_EX, Stall_EX, Mul_Done_EX
  );

  modport slave (
    input  ALU_Control_EX, ALU_A_EX, ALU_B_EX, Valid_EX, Flush_EX,
    output ALU_Result_EX, Zero_EX, Stall_EX, Mul_Done_EX
  );
endinterface

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU with optional iterative shift-add multiplier (op 1111), enabled by EX_ALU_MUL_EN.
// Without EX_ALU_MUL_EN the block is purely combinational and 1111 decodes as an unknown op.
//
// state | meaning
// IDLE  | single-cycle ops; a valid, unflushed 1111 stalls and starts the multiply
// BUSY  | retiring MUL_BITS_PER_CYCLE multiplier bits per cycle; flush aborts
// DONE  | product presented with Mul_Done_EX; always returns to IDLE
module ex_alu_unit #(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic         Clk,
  input  logic         Reset_n,
  ex_alu_unit_if.slave bus
);

  logic [31:0] w_alu;
  logic [31:0] w_result;

  always_comb begin
    w_alu = '0;
    case (bus.ALU_Control_EX)
      4'b0010: w_alu = bus.ALU_A_EX + bus.ALU_B_EX;
      4'b0110: w_alu = bus.ALU_A_EX - bus.ALU_B_EX;
      4'b0000: w_alu = bus.ALU_A_EX & bus.ALU_B_EX;
      4'b0001: w_alu = bus.ALU_A_EX | bus.ALU_B_EX;
      4'b0111: w_alu = {31'b0, $signed(bus.ALU_A_EX) < $signed(bus.ALU_B_EX)};
      default: w_alu = '0;
    endcase
  end

`ifdef EX_ALU_MUL_EN
  localparam int         N    = 32 / MUL_BITS_PER_CYCLE;
  localparam logic [5:0] LAST = 6'(N - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]  r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_acc;
  logic [5:0]  r_cnt;
  logic [31:0] w_sum;
  logic        w_start;

  assign w_start = (r_state == S_IDLE) & bus.Valid_EX
                 & (bus.ALU_Control_EX == 4'b1111) & ~bus.Flush_EX;

  // r_a shifts left and r_b right each iteration, so bit k of r_b always weights r_a << k
  always_comb begin
    w_sum = r_acc;
    for (int k = 0; k < MUL_BITS_PER_CYCLE; k++) begin
      if (r_b[k]) w_sum = w_sum + (r_a << k);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a     <= bus.ALU_A_EX;
            r_b     <= bus.ALU_B_EX;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.Flush_EX) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_sum;
            r_a   <= r_a << MUL_BITS_PER_CYCLE;
            r_b   <= r_b >> MUL_BITS_PER_CYCLE;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == LAST) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_result = w_alu;
    if (r_state == S_BUSY)      w_result = '0;
    else if (r_state == S_DONE) w_result = r_acc;
  end

  assign bus.Stall_EX    = w_start | ((r_state == S_BUSY) & ~bus.Flush_EX);
  assign bus.Mul_Done_EX = (r_state == S_DONE);
`else
  logic w_unused;

  assign w_unused = ^{Clk, Reset_n, bus.Valid_EX, bus.Flush_EX, (MUL_BITS_PER_CYCLE != 0)};
  assign w_result = w_alu;
  assign bus.Stall_EX    = 1'b0;
  assign bus.Mul_Done_EX = 1'b0;
`endif

  assign bus.ALU_Result_EX = w_result;
  assign bus.Zero_EX       = (w_result == '0);

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: driver queues expectations, negedge monitor checks each retirement.
module tb_ex_alu_unit;
  logic Clk = 1'b0;
  logic Reset_n;

  always #5 Clk = ~Clk;

  ex_alu_unit_if u_bus ();
  ex_alu_unit_if u_bus4 ();

  ex_alu_unit #(.MUL_BITS_PER_CYCLE(1)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(u_bus)
  );

  ex_alu_unit #(.MUL_BITS_PER_CYCLE(4)) u_dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(u_bus4)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    int          stalls;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int n_chk     = 0;
  int n_fail    = 0;
  int stall_cnt = 0;
  int done_seen = 0;
  int done_exp  = 0;

`ifdef EX_ALU_MUL_EN
  localparam int          MUL_STALLS  = 33;
  localparam int          MUL4_STALLS = 9;
  localparam logic [31:0] MUL_RES     = 32'h000B_000F;
  localparam logic        MUL_DONE    = 1'b1;
`else
  localparam int          MUL_STALLS  = 0;
  localparam int          MUL4_STALLS = 0;
  localparam logic [31:0] MUL_RES     = 32'h0;
  localparam logic        MUL_DONE    = 1'b0;
`endif

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (!Reset_n) begin
      stall_cnt = 0;
    end else begin
      if (u_bus.Mul_Done_EX) done_seen++;
      if (u_bus.Valid_EX && (u_bus.Flush_EX || !u_bus.Stall_EX)) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_retire: got result 0x%08h with empty scoreboard", u_bus.ALU_Result_EX);
        end else begin
          e = sb.pop_front();
          if (u_bus.Flush_EX) begin
            chk({e.name, ".stall_on_flush"}, 32'(u_bus.Stall_EX), 32'(0));
          end else begin
            chk({e.name, ".result"}, u_bus.ALU_Result_EX, e.res);
            chk({e.name, ".zero"}, 32'(u_bus.Zero_EX), 32'(e.res == 32'h0));
          end
          chk({e.name, ".stall_cycles"}, 32'(stall_cnt), 32'(e.stalls));
          chk({e.name, ".mul_done"}, 32'(u_bus.Mul_Done_EX), 32'(e.done));
        end
        stall_cnt = 0;
      end else if (u_bus.Valid_EX && u_bus.Stall_EX) begin
        stall_cnt++;
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int stalls,
                       input logic done, input bit scramble);
    exp_t e;
    bit ok;
    e.name = name; e.res = exp; e.stalls = stalls; e.done = done;
    sb.push_back(e);
    u_bus.ALU_Control_EX = op;
    u_bus.ALU_A_EX       = a;
    u_bus.ALU_B_EX       = b;
    u_bus.Valid_EX       = 1'b1;
    u_bus.Flush_EX       = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (!u_bus.Stall_EX) begin
        ok = 1'b1;
        break;
      end
      if (scramble) begin
        @(posedge Clk);
        #1;
        u_bus.ALU_A_EX = $urandom;
        u_bus.ALU_B_EX = $urandom;
      end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s.timeout: stall still high after 200 cycles, required release", name);
    end
    @(posedge Clk);
    #1;
    u_bus.Valid_EX = 1'b0;
  endtask

  initial begin
    exp_t e;
    int cnt4;
    Reset_n = 1'b0;
    u_bus.ALU_Control_EX = 4'b0000; u_bus.ALU_A_EX = '0; u_bus.ALU_B_EX = '0;
    u_bus.Valid_EX = 1'b0; u_bus.Flush_EX = 1'b0;
    u_bus4.ALU_Control_EX = 4'b0000; u_bus4.ALU_A_EX = '0; u_bus4.ALU_B_EX = '0;
    u_bus4.Valid_EX = 1'b0; u_bus4.Flush_EX = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset.stall", 32'(u_bus.Stall_EX), 32'(0));
    chk("reset.mul_done", 32'(u_bus.Mul_Done_EX), 32'(0));
    chk("reset.zero", 32'(u_bus.Zero_EX), 32'(1));
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

`ifdef EX_ALU_MUL_EN
    // Start a multiply without queuing it; reset mid-BUSY must drop it.
    u_bus.ALU_Control_EX = 4'b1111; u_bus.ALU_A_EX = 32'd3; u_bus.ALU_B_EX = 32'd4;
    u_bus.Valid_EX = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    u_bus.Valid_EX = 1'b0;
    #1;
    chk("reset_mid_busy.stall", 32'(u_bus.Stall_EX), 32'(0));
    chk("reset_mid_busy.mul_done", 32'(u_bus.Mul_Done_EX), 32'(0));
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
`endif

    issue("add_5_7",    4'b0010, 32'd5,          32'd7,          32'd12,         0, 1'b0, 1'b0);
    issue("sub_3_5",    4'b0110, 32'd3,          32'd5,          32'hFFFF_FFFE,  0, 1'b0, 1'b0);
    issue("slt_m1_1",   4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          0, 1'b0, 1'b0);
    issue("slt_1_m1",   4'b0111, 32'd1,          32'hFFFF_FFFF,  32'd0,          0, 1'b0, 1'b0);
    issue("or_f0_0f",   4'b0001, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  0, 1'b0, 1'b0);
    issue("and_mask",   4'b0000, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00,  0, 1'b0, 1'b0);
    issue("sub_9_9",    4'b0110, 32'd9,          32'd9,          32'd0,          0, 1'b0, 1'b0);
    issue("add_wrap",   4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          0, 1'b0, 1'b0);
    issue("op_0011",    4'b0011, 32'd6,          32'd3,          32'd0,          0, 1'b0, 1'b0);
    issue("op_1010",    4'b1010, 32'd6,          32'd3,          32'd0,          0, 1'b0, 1'b0);

    issue("mul_main", 4'b1111, 32'h0001_0003, 32'h0002_0005, MUL_RES, MUL_STALLS, MUL_DONE, 1'b0);
    if (MUL_DONE) done_exp++;

    // Bubble carrying op 1111 must neither stall nor start.
    u_bus.ALU_Control_EX = 4'b1111; u_bus.ALU_A_EX = 32'd3; u_bus.ALU_B_EX = 32'd3;
    u_bus.Valid_EX = 1'b0;
    @(negedge Clk);
    chk("bubble.stall", 32'(u_bus.Stall_EX), 32'(0));
    chk("bubble.result", u_bus.ALU_Result_EX, 32'd0);
    @(negedge Clk);
    chk("bubble.no_start", 32'(u_bus.Stall_EX), 32'(0));
    @(posedge Clk);
    #1;

`ifdef EX_ALU_MUL_EN
    e.name = "flush_mul"; e.res = 32'd0; e.stalls = 10; e.done = 1'b0;
    sb.push_back(e);
    u_bus.ALU_Control_EX = 4'b1111; u_bus.ALU_A_EX = 32'd11; u_bus.ALU_B_EX = 32'd13;
    u_bus.Valid_EX = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    u_bus.Flush_EX = 1'b1;
    @(posedge Clk);
    #1;
    u_bus.Flush_EX = 1'b0;
    u_bus.Valid_EX = 1'b0;
    issue("after_flush_add", 4'b0010, 32'd1, 32'd2, 32'd3, 0, 1'b0, 1'b0);

    issue("mul_7x6",  4'b1111, 32'd7,         32'd6, 32'd42,        33, 1'b1, 1'b1);
    issue("mul_ffx2", 4'b1111, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 1'b1, 1'b0);
    done_exp += 2;
`endif

    u_bus4.ALU_Control_EX = 4'b1111; u_bus4.ALU_A_EX = 32'h0001_0003; u_bus4.ALU_B_EX = 32'h0002_0005;
    u_bus4.Valid_EX = 1'b1;
    cnt4 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (!u_bus4.Stall_EX) break;
      cnt4++;
    end
    chk("mul4.stall_cycles", 32'(cnt4), 32'(MUL4_STALLS));
    chk("mul4.result", u_bus4.ALU_Result_EX, MUL_RES);
    chk("mul4.mul_done", 32'(u_bus4.Mul_Done_EX), 32'(MUL_DONE));
    @(posedge Clk);
    #1;
    u_bus4.Valid_EX = 1'b0;

    repeat (3) @(posedge Clk);
    #1;
    chk("mul_done_pulses", 32'(done_seen), 32'(done_exp));
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
